// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
//  Module   : iter_alu
//  Purpose  : Sequential ALU with single-cycle logic/arithmetic/shift/rotate
//             operations and iterative multi-cycle signed MUL (radix-2 Booth)
//             and signed DIV (restoring). Returns a double-width HI/LO result.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   rising-edge system clock
//    reset_n    in   asynchronous active-low reset
//    start      in   operation request, sampled only while ready=1
//    opcode     in   [3:0] operation select
//    A, B       in   [WIDTH-1:0] operands (B[SHW-1:0] = shift amount)
//    ready      out  engine idle and accepting start
//    done       out  one-cycle pulse, result valid
//    result_lo  out  primary result / product low / quotient
//    result_hi  out  product high / remainder; 0 for single-cycle ops
//    div_zero   out  sticky: DIV with B=0
//    op_err     out  sticky: undefined opcode
//  Optional feature (macro ITER_ALU_FLAGS_EN):
//    flag_z, flag_n, flag_c, flag_v   status flags updated with done
// ============================================================================
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic             op_err
`ifdef ITER_ALU_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
`endif
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_NEG  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SHRA = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;

  localparam logic [SHW-1:0] LAST_IT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL_IT = 2'd1,
    S_DIV_IT = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state, state_n;

  // Shared iteration registers:
  //   MUL: acc = Booth accumulator (one guard bit), q = multiplier, q1 = Booth bit
  //   DIV: acc = partial remainder, q = dividend magnitude -> quotient
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q1;
  logic [WIDTH-1:0] m;
  logic [SHW-1:0]   cnt;
  logic             is_div;
  logic             dz;
  logic             sign_a;
  logic             sign_b;

  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sc_lo;
  logic             sc_err;
  logic             sc_go;
  logic [2*WIDTH-1:0] rol_tmp;
  logic [2*WIDTH-1:0] ror_tmp;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;

  assign ready  = (state == S_IDLE);
  assign sh_amt = B[SHW-1:0];
  assign sc_go  = (state == S_IDLE) && start && (opcode != OP_MUL) && (opcode != OP_DIV);

  // Doubling the operand turns a rotate into a plain shift plus a slice.
  assign rol_tmp = {A, A} << sh_amt;
  assign ror_tmp = {A, A} >> sh_amt;

  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;

  // ---------------------------------------------------------------- single-cycle
  always_comb begin
    sc_lo  = '0;
    sc_err = 1'b0;
    case (opcode)
      OP_AND:  sc_lo = A & B;
      OP_OR:   sc_lo = A | B;
      OP_NOT:  sc_lo = ~A;
      OP_ADD:  sc_lo = A + B;
      OP_SUB:  sc_lo = A - B;
      OP_NEG:  sc_lo = -A;
      OP_SHL:  sc_lo = A << sh_amt;
      OP_SHR:  sc_lo = A >> sh_amt;
      OP_SHRA: sc_lo = $signed(A) >>> sh_amt;
      OP_ROL:  sc_lo = rol_tmp[2*WIDTH-1:WIDTH];
      OP_ROR:  sc_lo = ror_tmp[WIDTH-1:0];
      OP_MUL:  sc_lo = '0;
      OP_DIV:  sc_lo = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- iterative
  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    booth_sum = acc;
    case ({q[0], q1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  // Restoring step: shift next dividend bit into the remainder, try subtract.
  assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, m};

  always_comb begin
    fin_lo = q;
    fin_hi = acc[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        fin_lo = {WIDTH{1'b1}};
        fin_hi = q;                          // q holds the original A
      end else begin
        fin_lo = (sign_a ^ sign_b) ? -q : q;
        fin_hi = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL)      state_n = S_MUL_IT;
          else if (opcode == OP_DIV) state_n = (B == '0) ? S_FINISH : S_DIV_IT;
        end
      end
      S_MUL_IT: if (cnt == LAST_IT) state_n = S_FINISH;
      S_DIV_IT: if (cnt == LAST_IT) state_n = S_FINISH;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      q         <= '0;
      q1        <= 1'b0;
      m         <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      dz        <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            op_err   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            q1       <= 1'b0;
            if (opcode == OP_MUL) begin
              q      <= A;
              m      <= B;
              is_div <= 1'b0;
              dz     <= 1'b0;
            end else if (opcode == OP_DIV) begin
              is_div <= 1'b1;
              dz     <= (B == '0);
              sign_a <= A[WIDTH-1];
              sign_b <= B[WIDTH-1];
              q      <= (B == '0) ? A : a_mag;
              m      <= b_mag;
            end else begin
              result_lo <= sc_lo;
              result_hi <= '0;
              op_err    <= sc_err;
              done      <= 1'b1;
            end
          end
        end
        S_MUL_IT: begin
          acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q   <= {booth_sum[0], q[WIDTH-1:1]};
          q1  <= q[0];
          cnt <= cnt + 1'b1;
        end
        S_DIV_IT: begin
          if (div_trial[WIDTH]) begin
            acc <= div_shift;
            q   <= {q[WIDTH-2:0], 1'b0};
          end else begin
            acc <= div_trial;
            q   <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
        end
        S_FINISH: begin
          result_lo <= fin_lo;
          result_hi <= fin_hi;
          div_zero  <= is_div & dz;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ITER_ALU_FLAGS_EN
  // ---------------------------------------------------------------- flags
  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic [WIDTH:0] shl_full;
  logic [WIDTH:0] shr_full;
  logic [WIDTH:0] sra_full;
  logic           sc_c;
  logic           sc_v;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  // One extra bit catches the last bit shifted out (0 when amount is 0).
  assign shl_full = {1'b0, A} << sh_amt;
  assign shr_full = {A, 1'b0} >> sh_amt;
  assign sra_full = $signed({A, 1'b0}) >>> sh_amt;

  always_comb begin
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_c = add_full[WIDTH];
        sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (sc_lo[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_c = sub_full[WIDTH];
        sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (sc_lo[WIDTH-1] != A[WIDTH-1]);
      end
      OP_NEG: begin
        sc_c = (A == '0);
        sc_v = (A == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_SHL:  sc_c = shl_full[WIDTH];
      OP_SHR:  sc_c = shr_full[0];
      OP_SHRA: sc_c = sra_full[0];
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (sc_go) begin
      flag_z <= (sc_lo == '0);
      flag_n <= sc_lo[WIDTH-1];
      flag_c <= sc_c;
      flag_v <= sc_v;
    end else if (state == S_FINISH) begin
      flag_z <= (fin_lo == '0);
      flag_n <= fin_lo[WIDTH-1];
      flag_c <= 1'b0;
      flag_v <= !is_div && (fin_hi != {WIDTH{fin_lo[WIDTH-1]}});
    end
  end
`else
  logic unused_sc_go;
  assign unused_sc_go = sc_go;
`endif

endmodule
`default_nettype wire

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised sequential successor to the datapath's combinational logic unit.
- Adds arithmetic, shift, rotate, multiply and divide operations.
- Single-cycle ops complete one clock after start. MUL and DIV run as iterative multi-cycle engines.
- Uses a start/ready/done handshake and returns a double-width HI/LO result for the CPU datapath's HI and LO registers.

Parameters:
- WIDTH, 32, operand width in bits; any power of two ≥ 8.
- SHW, $clog2(WIDTH), shift-amount field width; derived, do not override.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- opcode  input  4  operation select.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B, or shift amount in B[SHW-1:0].
- ready  output  1  high in IDLE; engine accepts start.
- done  output  1  one-cycle pulse; result valid.
- result_lo  output  WIDTH  primary result / product low / quotient.
- result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
- div_zero  output  1  sticky until next accepted start; DIV with B=0.
- op_err  output  1  sticky until next accepted start; undefined opcode.

Behaviour:
- Reset (asynchronous, reset_n=0), any state, including mid-MUL/DIV:
  - state=IDLE, ready=1, done=0.
  - result_lo=0, result_hi=0, div_zero=0, op_err=0.
  - Iteration counter cleared. A partial operation is discarded with no done.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 NOT A; 0011 ADD; 0100 SUB (A-B); 0101 NEG (-A).
  - 0110 SHL; 0111 SHR logical; 1000 SHRA arithmetic; 1001 ROL; 1010 ROR.
  - 1011 MUL signed; 1100 DIV signed.
  - 1101-1111 undefined.
- Arithmetic: ADD/SUB/NEG wrap modulo 2^WIDTH.
- Shifts/rotates: use B[SHW-1:0] only; upper B bits ignored; amount 0 returns A.
- States: IDLE, MUL_IT, DIV_IT, FINISH.
- IDLE, start=1, single-cycle or undefined opcode:
  - Result registered on that edge; done=1 the following cycle; state stays IDLE, so ready stays 1.
  - Back-to-back single-cycle starts are allowed, one per cycle.
  - Undefined opcode: result_lo=result_hi=0, op_err=1, done still pulses.
- IDLE, start=1, MUL:
  - Latch A and B, go to MUL_IT, ready=0.
  - Radix-2 Booth; one iteration per cycle for WIDTH cycles; then FINISH.
  - FINISH writes the 2·WIDTH product as {result_hi, result_lo}; returns to IDLE with done=1.
- IDLE, start=1, DIV:
  - Latch operands; record the signs of A and B.
  - Divide magnitudes with restoring division in DIV_IT, WIDTH cycles.
  - FINISH applies signs: quotient truncates toward zero; remainder takes the sign of A. result_lo=quotient, result_hi=remainder.
- DIV with B=0:
  - No iteration; go directly to FINISH.
  - result_lo=all ones, result_hi=A, div_zero=1.
- Latency, from the start edge:
  - Single-cycle ops: done 1 cycle later.
  - MUL, and DIV with B≠0: done WIDTH+2 cycles later.
  - DIV with B=0: done 2 cycles later.
- Hold and abort rules:
  - start while ready=0 is ignored.
  - Changes to opcode, A or B during MUL_IT/DIV_IT have no effect.
  - Results hold their value until the next done.
- Sticky flags: cleared on the edge that accepts a new start; set at done.

Optional Feature:
- Macro: ITER_ALU_FLAGS_EN.
- Defined: adds outputs flag_z, flag_n, flag_c, flag_v, each 1 bit, all updated with done and reset to 0.
  - flag_z: result_lo==0.
  - flag_n: result_lo MSB.
  - flag_c: carry-out for ADD, no-borrow for SUB/NEG, last bit shifted out for shifts; 0 otherwise.
  - flag_v: signed overflow for ADD/SUB/NEG; for MUL, set when result_hi is not the sign extension of result_lo.
- Undefined: those ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset then AND, A=F0F0F0F0, B=FF00FF00 -> next cycle done=1, result_lo=F000F000, result_hi=0.
- ADD 7FFFFFFF+1 -> result_lo=80000000; with flags enabled, flag_v=1, flag_n=1, flag_c=0.
- Rotate and shift:
  - ROR A=00000001, B=00000021 (amount 1) -> result_lo=80000000.
  - SHRA A=80000000, B=4 -> result_lo=F8000000.
- MUL -3×7 -> ready=0 for 33 cycles, done at start+34, result_hi=FFFFFFFF, result_lo=FFFFFFEB. A second start held high mid-operation is ignored.
- DIV -17/5 -> done at start+34, result_lo=FFFFFFFD (-3), result_hi=FFFFFFFE (-2).
- DIV 10/0 -> done at start+2, div_zero=1, result_lo=FFFFFFFF, result_hi=0000000A.
- Reset mid-operation: assert reset_n=0 mid-MUL at cycle 10 -> outputs zero immediately. No done follows; ready=1 after release.
- Undefined opcode 1110 -> op_err=1, then cleared by the next start.
